// File: rtl/sdram_sched_pkg.sv
// ---------------------------------------------------------------------------
// sdram_sched_pkg
//   Shared definitions for the SDRAM burst scheduler:
//   - scheduler state encoding
//   - default geometry (burst length mirrors SC_BL from Sdram_Params.h)
//   - COLS / COL_LAST for the default geometry and a helper that derives
//     the last burst-aligned column for any geometry
// ---------------------------------------------------------------------------
package sdram_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_WAIT  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4
    } sched_state_t;

    localparam int DEF_ASIZE       = 13;
    localparam int DEF_BSIZE       = 2;
    localparam int DEF_COL_WIDTH   = 9;
    localparam int DEF_SC_BL       = 8;     // SC_BL from Sdram_Params.h
    localparam int DEF_TIMEOUT_CYC = 1023;

    localparam int COLS     = 2 ** DEF_COL_WIDTH;
    localparam int COL_LAST = COLS - DEF_SC_BL;

    // Column address of the last burst that fits in a row.
    function automatic int col_last_of(input int col_width, input int bl);
        return (2 ** col_width) - bl;
    endfunction

endpackage

// File: rtl/sdram_burst_sched_addr_ptr.sv
// ---------------------------------------------------------------------------
// sdram_addr_ptr
//   {row,col} burst pointer. On i_adv the column steps by SC_BL; after the
//   last burst of a row the column returns to 0 and the row increments,
//   rolling from the last row back to row 0. i_clr zeroes the pointer and
//   takes priority over a same-cycle advance.
// Ports
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_adv         advance by one burst
//   i_clr         clear to {0,0}
//   o_col, o_row  current pointer
//   o_last        pointer sits on the last burst of the last row
// ---------------------------------------------------------------------------
module sdram_addr_ptr
    import sdram_sched_pkg::*;
#(
    parameter int ASIZE     = DEF_ASIZE,
    parameter int COL_WIDTH = DEF_COL_WIDTH,
    parameter int SC_BL     = DEF_SC_BL
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_adv,
    input  logic                 i_clr,
    output logic [COL_WIDTH-1:0] o_col,
    output logic [ASIZE-1:0]     o_row,
    output logic                 o_last
);

    localparam logic [COL_WIDTH-1:0] COL_LAST_P = COL_WIDTH'(col_last_of(COL_WIDTH, SC_BL));
    localparam logic [ASIZE-1:0]     ROW_LAST_P = {ASIZE{1'b1}};

    logic [COL_WIDTH-1:0] r_col;
    logic [ASIZE-1:0]     r_row;

    // Pointer register: clear beats advance, row rolls over after the last row.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_adv) begin
            if (r_col == COL_LAST_P) begin
                r_col <= '0;
                if (r_row == ROW_LAST_P) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + ASIZE'(1);
                end
            end else begin
                r_col <= r_col + COL_WIDTH'(SC_BL);
            end
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_last = (r_col == COL_LAST_P) && (r_row == ROW_LAST_P);

endmodule

// File: rtl/sdram_burst_sched.sv
// ---------------------------------------------------------------------------
// sdram_burst_sched
//   Burst scheduler in front of sdram_control. Arbitrates a write and a read
//   requester, issues one single-cycle Wr/Rd command per burst, waits for the
//   matching data-done pulse (or aborts after TIMEOUT_CYC wait cycles) and
//   keeps independent write/read {row,col} pointers.
//   Timeline of a burst: grant edge -> ack cycle (ISSUE) -> command cycle
//   (first WAIT cycle) -> ... -> done edge -> done pulse (IDLE cycle).
// Configuration
//   SDRAM_SCHED_RR_EN  defined: round-robin on simultaneous requests
//                      undefined: write always wins
// Ports
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_init_done                   grants allowed only while high
//   i_wr_req/i_wr_bank            write requester (bank sampled at grant)
//   o_wr_ack/o_wr_done            write grant / finish pulses
//   i_rd_req/i_rd_bank            read requester (bank sampled at grant)
//   o_rd_ack/o_rd_done            read grant / finish pulses
//   i_addr_clr                    zero both pointers, clear o_timeout_err
//   o_wr/o_rd                     command pulses to sdram_control
//   o_caddr/o_raddr/o_baddr       burst address, held from grant to grant
//   i_wdata_done/i_rdata_done     burst completion from sdram_control
//   o_busy                        scheduler not idle
//   o_wrap                        a pointer rolled from the last row to row 0
//   o_timeout_err                 sticky burst-abort flag
// ---------------------------------------------------------------------------
module sdram_burst_sched
    import sdram_sched_pkg::*;
#(
    parameter int ASIZE       = DEF_ASIZE,
    parameter int BSIZE       = DEF_BSIZE,
    parameter int COL_WIDTH   = DEF_COL_WIDTH,
    parameter int SC_BL       = DEF_SC_BL,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_init_done,
    input  logic             i_wr_req,
    input  logic [BSIZE-1:0] i_wr_bank,
    output logic             o_wr_ack,
    output logic             o_wr_done,
    input  logic             i_rd_req,
    input  logic [BSIZE-1:0] i_rd_bank,
    output logic             o_rd_ack,
    output logic             o_rd_done,
    input  logic             i_addr_clr,
    output logic             o_wr,
    output logic             o_rd,
    output logic [ASIZE-1:0] o_caddr,
    output logic [ASIZE-1:0] o_raddr,
    output logic [BSIZE-1:0] o_baddr,
    input  logic             i_wdata_done,
    input  logic             i_rdata_done,
    output logic             o_busy,
    output logic             o_wrap,
    output logic             o_timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    sched_state_t         r_state;
    logic [TW-1:0]        r_tmo;
    logic                 r_wr_ack, r_rd_ack, r_wr_done, r_rd_done;
    logic                 r_wr, r_rd, r_busy, r_wrap, r_err;
    logic [ASIZE-1:0]     r_caddr, r_raddr;
    logic [BSIZE-1:0]     r_baddr;
`ifdef SDRAM_SCHED_RR_EN
    logic                 r_last_wr;     // 1: last grant went to the writer
`endif

    logic [COL_WIDTH-1:0] w_wr_col, w_rd_col;
    logic [ASIZE-1:0]     w_wr_row, w_rd_row;
    logic                 w_wr_last, w_rd_last;
    logic                 w_wr_adv, w_rd_adv;
    logic                 w_tmo_hit, w_tmo_abort, w_pick_wr;

    // Advance/abort decode and write-vs-read arbitration.
    always_comb begin
        w_wr_adv    = (r_state == ST_WR_WAIT) && i_wdata_done;
        w_rd_adv    = (r_state == ST_RD_WAIT) && i_rdata_done;
        w_tmo_hit   = (r_tmo == TW'(TIMEOUT_CYC - 1));
        w_tmo_abort = w_tmo_hit &&
                      (((r_state == ST_WR_WAIT) && !i_wdata_done) ||
                       ((r_state == ST_RD_WAIT) && !i_rdata_done));
`ifdef SDRAM_SCHED_RR_EN
        // On a tie the side that was not served last wins.
        w_pick_wr   = i_wr_req && !(i_rd_req && r_last_wr);
`else
        w_pick_wr   = i_wr_req;
`endif
    end

    sdram_addr_ptr #(.ASIZE(ASIZE), .COL_WIDTH(COL_WIDTH), .SC_BL(SC_BL)) u_wr_ptr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_adv  (w_wr_adv),
        .i_clr  (i_addr_clr),
        .o_col  (w_wr_col),
        .o_row  (w_wr_row),
        .o_last (w_wr_last)
    );

    sdram_addr_ptr #(.ASIZE(ASIZE), .COL_WIDTH(COL_WIDTH), .SC_BL(SC_BL)) u_rd_ptr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_adv  (w_rd_adv),
        .i_clr  (i_addr_clr),
        .o_col  (w_rd_col),
        .o_row  (w_rd_row),
        .o_last (w_rd_last)
    );

    // Scheduler FSM with registered pulses, busy flag and latched burst address.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_tmo     <= '0;
            r_wr_ack  <= 1'b0;
            r_rd_ack  <= 1'b0;
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_busy    <= 1'b0;
            r_caddr   <= '0;
            r_raddr   <= '0;
            r_baddr   <= '0;
`ifdef SDRAM_SCHED_RR_EN
            r_last_wr <= 1'b0;
`endif
        end else begin
            r_wr_ack  <= 1'b0;
            r_rd_ack  <= 1'b0;
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tmo <= '0;
                    if (i_init_done && (i_wr_req || i_rd_req)) begin
                        r_busy <= 1'b1;
                        if (w_pick_wr) begin
                            r_state  <= ST_WR_ISSUE;
                            r_wr_ack <= 1'b1;
                            r_baddr  <= i_wr_bank;
                            r_caddr  <= ASIZE'(w_wr_col);
                            r_raddr  <= w_wr_row;
                        end else begin
                            r_state  <= ST_RD_ISSUE;
                            r_rd_ack <= 1'b1;
                            r_baddr  <= i_rd_bank;
                            r_caddr  <= ASIZE'(w_rd_col);
                            r_raddr  <= w_rd_row;
                        end
`ifdef SDRAM_SCHED_RR_EN
                        r_last_wr <= w_pick_wr;
`endif
                    end
                end
                ST_WR_ISSUE: begin
                    r_wr    <= 1'b1;
                    r_state <= ST_WR_WAIT;
                end
                ST_RD_ISSUE: begin
                    r_rd    <= 1'b1;
                    r_state <= ST_RD_WAIT;
                end
                ST_WR_WAIT: begin
                    if (i_wdata_done) begin
                        r_wr_done <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end else begin
                        r_tmo     <= r_tmo + TW'(1);
                    end
                end
                ST_RD_WAIT: begin
                    if (i_rdata_done) begin
                        r_rd_done <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end else begin
                        r_tmo     <= r_tmo + TW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Wrap pulse: an advance from the very last burst, unless a clear overrides it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= !i_addr_clr &&
                      ((w_wr_adv && w_wr_last) || (w_rd_adv && w_rd_last));
        end
    end

    // Sticky timeout flag; an address clear wins over a same-cycle abort.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (i_addr_clr) begin
            r_err <= 1'b0;
        end else if (w_tmo_abort) begin
            r_err <= 1'b1;
        end
    end

    assign o_wr_ack      = r_wr_ack;
    assign o_rd_ack      = r_rd_ack;
    assign o_wr_done     = r_wr_done;
    assign o_rd_done     = r_rd_done;
    assign o_wr          = r_wr;
    assign o_rd          = r_rd;
    assign o_caddr       = r_caddr;
    assign o_raddr       = r_raddr;
    assign o_baddr       = r_baddr;
    assign o_busy        = r_busy;
    assign o_wrap        = r_wrap;
    assign o_timeout_err = r_err;

endmodule

// File: tb/tb_sdram_burst_sched.sv
// ---------------------------------------------------------------------------
// tb_sdram_burst_sched
//   Self-checking bench for sdram_burst_sched. A burst-level model (linear
//   burst index per pointer, age of the current burst since grant) predicts
//   every output each cycle; a responder stands in for sdram_control.
//   Small geometry (64 rows x 64 columns) keeps the pointer rollover reachable.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_burst_sched;

    localparam int ASIZE       = 6;
    localparam int BSIZE       = 2;
    localparam int COL_WIDTH   = 6;
    localparam int SC_BL       = 8;
    localparam int TIMEOUT_CYC = 1023;
    localparam int COLS        = 1 << COL_WIDTH;
    localparam int NB          = (1 << (ASIZE + COL_WIDTH)) / SC_BL;
`ifdef SDRAM_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, init_done = 1'b0;
    logic wr_req = 1'b0, rd_req = 1'b0, addr_clr = 1'b0;
    logic wdone = 1'b0, rdone = 1'b0;
    logic [BSIZE-1:0] wr_bank = '0, rd_bank = '0;
    logic o_wr_ack, o_wr_done, o_rd_ack, o_rd_done, o_wr, o_rd, o_busy, o_wrap, o_err;
    logic [ASIZE-1:0] o_caddr, o_raddr;
    logic [BSIZE-1:0] o_baddr;

    sdram_burst_sched #(.ASIZE(ASIZE), .BSIZE(BSIZE), .COL_WIDTH(COL_WIDTH),
                        .SC_BL(SC_BL), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .i_clk(clk), .i_rst(rst), .i_init_done(init_done),
        .i_wr_req(wr_req), .i_wr_bank(wr_bank), .o_wr_ack(o_wr_ack), .o_wr_done(o_wr_done),
        .i_rd_req(rd_req), .i_rd_bank(rd_bank), .o_rd_ack(o_rd_ack), .o_rd_done(o_rd_done),
        .i_addr_clr(addr_clr), .o_wr(o_wr), .o_rd(o_rd),
        .o_caddr(o_caddr), .o_raddr(o_raddr), .o_baddr(o_baddr),
        .i_wdata_done(wdone), .i_rdata_done(rdone),
        .o_busy(o_busy), .o_wrap(o_wrap), .o_timeout_err(o_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_wr_idx = 0, m_rd_idx = 0;       // bursts completed, modulo NB
    bit  m_in = 1'b0, m_is_wr = 1'b0, m_last_wr = 1'b0;
    int  m_age = 0;                        // 1 = ack cycle, 2 = command cycle
    int  m_wr_done_cnt = 0, m_rd_done_cnt = 0;
    logic [ASIZE-1:0] e_caddr = '0, e_raddr = '0;
    logic [BSIZE-1:0] e_baddr = '0;
    bit  e_wr_ack = 1'b0, e_rd_ack = 1'b0, e_wr_done = 1'b0, e_rd_done = 1'b0;
    bit  e_wrap = 1'b0, e_err = 1'b0;

    task automatic model_step();
        bit adv_w, adv_r, tmo, g_wr;
        int w;
        if (rst) begin
            m_wr_idx = 0; m_rd_idx = 0; m_in = 0; m_is_wr = 0; m_last_wr = 0; m_age = 0;
            e_caddr = '0; e_raddr = '0; e_baddr = '0;
            e_wr_ack = 0; e_rd_ack = 0; e_wr_done = 0; e_rd_done = 0; e_wrap = 0; e_err = 0;
            return;
        end
        e_wr_ack = 0; e_rd_ack = 0; e_wr_done = 0; e_rd_done = 0; e_wrap = 0;
        adv_w = 0; adv_r = 0; tmo = 0;
        if (!m_in) begin
            if (init_done && (wr_req || rd_req)) begin
                g_wr = wr_req && !(RR && rd_req && m_last_wr);
                m_in = 1; m_is_wr = g_wr; m_age = 1; m_last_wr = g_wr;
                w = (g_wr ? m_wr_idx : m_rd_idx) * SC_BL;
                e_caddr = ASIZE'(w % COLS);
                e_raddr = ASIZE'(w / COLS);
                e_baddr = g_wr ? wr_bank : rd_bank;
                if (g_wr) e_wr_ack = 1; else e_rd_ack = 1;
            end
        end else if (m_age >= 2 && (m_is_wr ? wdone : rdone)) begin
            m_in = 0;
            if (m_is_wr) begin e_wr_done = 1; adv_w = 1; m_wr_done_cnt++; end
            else begin e_rd_done = 1; adv_r = 1; m_rd_done_cnt++; end
        end else if (m_age == TIMEOUT_CYC + 1) begin
            m_in = 0; tmo = 1;
        end else begin
            m_age++;
        end
        if (addr_clr) begin
            m_wr_idx = 0; m_rd_idx = 0; e_err = 0;
        end else begin
            if (adv_w) begin
                if (m_wr_idx == NB - 1) begin m_wr_idx = 0; e_wrap = 1; end
                else m_wr_idx++;
            end
            if (adv_r) begin
                if (m_rd_idx == NB - 1) begin m_rd_idx = 0; e_wrap = 1; end
                else m_rd_idx++;
            end
            if (tmo) e_err = 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare + observers ----------------
    int obs_wr_done = 0, obs_wrap = 0, obs_acks = 0;
    bit ack_log[$];

    initial forever begin
        @(negedge clk);
        chk("wr_ack",  o_wr_ack,  e_wr_ack);
        chk("rd_ack",  o_rd_ack,  e_rd_ack);
        chk("wr_done", o_wr_done, e_wr_done);
        chk("rd_done", o_rd_done, e_rd_done);
        chk("wr_cmd",  o_wr, m_in && m_is_wr && m_age == 2);
        chk("rd_cmd",  o_rd, m_in && !m_is_wr && m_age == 2);
        chk("busy",    o_busy, m_in);
        chk("caddr",   o_caddr, e_caddr);
        chk("raddr",   o_raddr, e_raddr);
        chk("baddr",   o_baddr, e_baddr);
        chk("wrap",    o_wrap, e_wrap);
        chk("tmo_err", o_err, e_err);
        if (o_wr_done) obs_wr_done++;
        if (o_wrap) obs_wrap++;
        if (o_wr_ack || o_rd_ack) begin obs_acks++; ack_log.push_back(o_wr_ack); end
    end

    // ---------------- sdram_control stand-in ----------------
    int resp_max_delay = 3;
    bit suppress = 1'b0, spur_en = 1'b0;

    initial begin
        int wc, rc;
        bit wp, rp;
        wc = 0; rc = 0; wp = 0; rp = 0;
        forever begin
            @(negedge clk);
            wdone = 1'b0; rdone = 1'b0;
            if (rst) begin
                wp = 0; rp = 0;
            end else begin
                if (wp) begin
                    if (wc == 0) begin wdone = 1'b1; wp = 0; end else wc--;
                end else if (spur_en && $urandom_range(7, 0) == 0) wdone = 1'b1;
                if (rp) begin
                    if (rc == 0) begin rdone = 1'b1; rp = 0; end else rc--;
                end else if (spur_en && $urandom_range(7, 0) == 0) rdone = 1'b1;
                if (o_wr && !suppress) begin wp = 1; wc = $urandom_range(resp_max_delay, 0); end
                if (o_rd && !suppress) begin rp = 1; rc = $urandom_range(resp_max_delay, 0); end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        tick(); addr_clr = 1'b1;
        tick(); addr_clr = 1'b0;
    endtask

    // Keep requests as set until `total` more bursts have completed.
    task automatic wait_bursts(input int total, input int budget);
        int base, c;
        base = m_wr_done_cnt + m_rd_done_cnt;
        c = 0;
        while ((m_wr_done_cnt + m_rd_done_cnt - base) < total && c < budget) begin
            tick(); c++;
        end
        chk("burst_budget", (c >= budget), 0);
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    // One burst from grant to idle; returns cycles with Busy high.
    task automatic issue_one(input bit is_wr, output int busy_cyc);
        int c;
        c = 0; busy_cyc = 0;
        if (is_wr) wr_req = 1'b1; else rd_req = 1'b1;
        tick();
        while (!(o_wr_ack || o_rd_ack) && c < 20) begin tick(); c++; end
        chk("grant_budget", (c >= 20), 0);
        wr_req = 1'b0; rd_req = 1'b0;
        c = 0;
        while (o_busy && c < 1200) begin busy_cyc++; tick(); c++; end
        chk("idle_budget", (c >= 1200), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int bc, base_done, base_wrap, base_acks;

        // Reset state
        tick(); tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_wr", o_wr, 0);
        chk("rst_caddr", o_caddr, 0);
        chk("rst_err", o_err, 0);
        rst = 1'b0;
        tick();
        init_done = 1'b1;

        // 1: 100 write bursts to bank 2
        base_done = obs_wr_done;
        wr_bank = 2'd2; wr_req = 1'b1;
        wait_bursts(100, 2000);
        tick(); tick();
        chk("t1_done_pulses", obs_wr_done - base_done, 100);
        chk("t1_last_col", o_caddr, 24);
        chk("t1_last_row", o_raddr, 12);
        chk("t1_bank", o_baddr, 2);
        chk("t1_model_idx", m_wr_idx, 100);

        // 2: clear, then 100 read bursts from bank 1
        pulse_clr();
        rd_bank = 2'd1; rd_req = 1'b1;
        wait_bursts(100, 2000);
        tick(); tick();
        chk("t2_last_col", o_caddr, 24);
        chk("t2_last_row", o_raddr, 12);
        chk("t2_bank", o_baddr, 1);
        chk("t2_wr_idx_cleared", m_wr_idx, 0);

        // 3: both requesters held
        ack_log.delete();
        wr_req = 1'b1; rd_req = 1'b1;
        wait_bursts(6, 200);
        tick(); tick();
        chk("t3_grants", ack_log.size(), 6);
        for (int i = 0; i < ack_log.size(); i++)
            chk("t3_grant_side", ack_log[i], RR ? ((i % 2) == 0) : 1'b1);

        // 4: roll the write pointer over the last row
        pulse_clr();
        resp_max_delay = 0;
        base_wrap = obs_wrap;
        wr_req = 1'b1;
        wait_bursts(NB - 1, 20000);
        tick(); tick();
        chk("t4_pre_col", o_caddr, 48);
        chk("t4_pre_row", o_raddr, 63);
        chk("t4_no_wrap_yet", obs_wrap - base_wrap, 0);
        issue_one(1'b1, bc);
        tick();
        chk("t4_last_col", o_caddr, 56);
        chk("t4_last_row", o_raddr, 63);
        chk("t4_wrap_pulse", obs_wrap - base_wrap, 1);
        issue_one(1'b1, bc);
        chk("t4_next_col", o_caddr, 0);
        chk("t4_next_row", o_raddr, 0);

        // 5: suppressed Wdata_done -> timeout
        base_done = obs_wr_done;
        suppress = 1'b1;
        issue_one(1'b1, bc);
        tick();
        chk("t5_busy_cycles", bc, TIMEOUT_CYC + 1);
        chk("t5_err", o_err, 1);
        chk("t5_no_done", obs_wr_done - base_done, 0);
        chk("t5_tmo_col", o_caddr, 8);
        suppress = 1'b0;
        issue_one(1'b1, bc);
        chk("t5_retry_col", o_caddr, 8);
        chk("t5_err_kept", o_err, 1);
        pulse_clr();
        tick();
        chk("t5_err_cleared", o_err, 0);

        // Random traffic
        resp_max_delay = 5;
        spur_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            wr_req    = ($urandom_range(2, 0) != 0);
            rd_req    = ($urandom_range(2, 0) != 0);
            wr_bank   = BSIZE'($urandom_range(3, 0));
            rd_bank   = BSIZE'($urandom_range(3, 0));
            addr_clr  = ($urandom_range(63, 0) == 0);
            init_done = ($urandom_range(49, 0) != 0);
        end
        wr_req = 1'b0; rd_req = 1'b0; addr_clr = 1'b0; init_done = 1'b1; spur_en = 1'b0;
        for (int c = 0; c < 50 && o_busy; c++) tick();
        chk("rand_idle", o_busy, 0);
        issue_one(1'b1, bc);   // guarantees a non-zero write pointer

        // 6: reset while the read command is on the bus
        suppress = 1'b1;
        rd_req = 1'b1;
        bc = 0;
        tick();
        while (!o_rd && bc < 20) begin tick(); bc++; end
        chk("t6_rd_seen", o_rd, 1);
        rd_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_busy_async", o_busy, 0);
        chk("t6_rd_async", o_rd, 0);
        init_done = 1'b0;
        tick();
        rst = 1'b0;
        suppress = 1'b0;
        base_acks = obs_acks;
        wr_req = 1'b1;
        repeat (20) tick();
        chk("t6_no_grant_uninit", obs_acks - base_acks, 0);
        init_done = 1'b1;
        bc = 0;
        while (!o_wr_ack && bc < 10) begin tick(); bc++; end
        chk("t6_grant_after_init", o_wr_ack, 1);
        chk("t6_ptr_col0", o_caddr, 0);
        chk("t6_ptr_row0", o_raddr, 0);
        wr_req = 1'b0;
        for (int c = 0; c < 50 && o_busy; c++) tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
